// File: rtl/down_count_timer_pkg.sv
// Shared types and helpers for the down_count_timer block.
package down_count_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  // Width of the prescale counter. This is $clog2(PRESCALE), but never
  // less than 1, so that PRESCALE=1 still gets a legal vector.
  function automatic int pcnt_width(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/down_count_timer_tick_prescaler.sv
// tick_prescaler: counts qualified tick_en pulses and emits one step every
// PRESCALE of them. clr has priority and returns the count to zero.
module tick_prescaler
  import down_count_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int              PW   = pcnt_width(PRESCALE);
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;

  // A step is the enabled tick that lands on the last prescale slot.
  assign step = en && (pcnt_q == LAST);

  // Next prescale count: clear, wrap on step, or advance on enabled tick.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (step) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  // Prescale count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/down_count_timer.sv
// down_count_timer: loadable down-counter with IDLE/RUN/PAUSE control and a
// one-cycle done pulse. Optional periodic mode is enabled by defining
// DOWN_COUNT_TIMER_AUTO_RELOAD_EN; without it the timer is one-shot.
//
// Handshake: there is no valid/ready pair. load, start and pause are sampled
// on every rising edge; start is only honoured in IDLE, pause is a level.
module down_count_timer
  import down_count_timer_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done
);

`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             step;
  logic             pcnt_en;
  logic             pcnt_clr;

  // The prescaler only advances while running.
  assign pcnt_en = tick_en && (state_q == RUN);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (pcnt_en),
    .clr   (pcnt_clr),
    .step  (step)
  );

  // Next-state, count, reload and done logic. load wins over everything
  // that would touch the count in the same cycle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    pcnt_clr = load;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          pcnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (!load) begin
          if (pause) begin
            state_d = PAUSE;
          end else if (count_q == '0) begin
            // Started (or loaded) at zero: finish without consuming steps.
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (step) begin
            if (count_q == WIDTH'(1)) begin
              done_d = 1'b1;
              if (AUTO_RELOAD && (reload_q != '0)) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
      end
      PAUSE: begin
        if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any exit from RUN restarts the prescale phase.
    if ((state_q == RUN) && (state_d != RUN)) begin
      pcnt_clr = 1'b1;
    end
  end

  // State, count, reload and done registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign Q    = count_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_down_count_timer.sv
// Bench for down_count_timer: two instances (PRESCALE=1 and PRESCALE=3)
// share one stimulus stream and are compared each cycle against a
// tick-accumulator reference model, plus literal expectations for the
// directed scenarios.
module tb_down_count_timer;

  logic       clk;
  logic       reset;
  logic       tick_en;
  logic       load;
  logic [2:0] load_val;
  logic       start;
  logic       pause;
  logic [2:0] q_a, q_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int n_checks;
  int n_errors;

  // Reference model, index 0 -> PRESCALE 1, index 1 -> PRESCALE 3.
  // mode: 0 idle, 1 counting, 2 frozen.
  int m_q    [2];
  int m_rl   [2];
  int m_acc  [2];
  int m_mode [2];
  bit m_done [2];

`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  down_count_timer #(.WIDTH(3), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .tick_en(tick_en), .load(load),
    .load_val(load_val), .start(start), .pause(pause),
    .Q(q_a), .busy(busy_a), .done(done_a)
  );

  down_count_timer #(.WIDTH(3), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(reset), .tick_en(tick_en), .load(load),
    .load_val(load_val), .start(start), .pause(pause),
    .Q(q_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs_of(input int i);
    return (i == 0) ? {q_a, busy_a, done_a} : {q_b, busy_b, done_b};
  endfunction

  function automatic logic [4:0] exp_of(input int i);
    return {3'(m_q[i]), (m_mode[i] != 0), m_done[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 0; m_rl[i] = 0; m_acc[i] = 0; m_mode[i] = 0; m_done[i] = 0;
    end
  endtask

  // One clock edge of the behavioural timer with prescale p.
  task automatic model_edge(input int i, input int p);
    m_done[i] = 0;
    if (m_mode[i] == 0) begin
      if (load) begin m_q[i] = load_val; m_rl[i] = load_val; end
      if (start) m_mode[i] = 1;
      m_acc[i] = 0;
    end else if (m_mode[i] == 2) begin
      if (load) begin m_q[i] = load_val; m_rl[i] = load_val; end
      m_acc[i] = 0;
      if (!pause) m_mode[i] = 1;
    end else begin
      if (load) begin
        m_q[i] = load_val; m_rl[i] = load_val; m_acc[i] = 0;
      end else if (pause) begin
        m_mode[i] = 2; m_acc[i] = 0;
      end else if (m_q[i] == 0) begin
        m_done[i] = 1; m_mode[i] = 0; m_acc[i] = 0;
      end else if (tick_en) begin
        m_acc[i] = m_acc[i] + 1;
        if (m_acc[i] == p) begin
          m_acc[i] = 0;
          if (m_q[i] == 1) begin
            m_done[i] = 1;
            if (AUTO && m_rl[i] != 0) m_q[i] = m_rl[i];
            else begin m_q[i] = 0; m_mode[i] = 0; end
          end else begin
            m_q[i] = m_q[i] - 1;
          end
        end
      end
    end
  endtask

  // Advance one edge, update the model, settle just after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge(0, 1);
    model_edge(1, 3);
    #1;
  endtask

  task automatic idle_inputs();
    tick_en = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = 3'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs_of(i) !== 5'b0) begin
        n_errors++;
        $display("FAIL reset_state dut%0d: got %b expected %b", i, obs_of(i), 5'b0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drain both instances with tick_en high, checking against the model.
  task automatic test_drain(input int n);
    idle_inputs();
    tick_en = 1'b1;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_of(i) !== exp_of(i)) begin
          n_errors++;
          $display("FAIL drain dut%0d cyc%0d: got %b expected %b", i, c, obs_of(i), exp_of(i));
        end
      end
    end
  endtask

  task automatic test_count_p1();
    logic [4:0] want;
    idle_inputs();
    load = 1'b1; load_val = 3'd5; start = 1'b1; tick_en = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      want = {3'(5 - k), (k < 5), (k == 5)};
      n_checks++;
      if (obs_of(0) !== want) begin
        n_errors++;
        $display("FAIL count_p1 edge%0d: got %b expected %b", k, obs_of(0), want);
      end
      n_checks++;
      if (obs_of(1) !== exp_of(1)) begin
        n_errors++;
        $display("FAIL count_p1 dut1 edge%0d: got %b expected %b", k, obs_of(1), exp_of(1));
      end
    end
  endtask

  task automatic test_prescale();
    logic [4:0] want;
    int qv;
    idle_inputs();
    load = 1'b1; load_val = 3'd2; start = 1'b1; tick_en = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      qv = (e < 3) ? 2 : (e < 6) ? 1 : 0;
      want = {3'(qv), (e < 6), (e == 6)};
      n_checks++;
      if (obs_of(1) !== want) begin
        n_errors++;
        $display("FAIL prescale3 edge%0d: got %b expected %b", e, obs_of(1), want);
      end
      n_checks++;
      if (obs_of(0) !== exp_of(0)) begin
        n_errors++;
        $display("FAIL prescale dut0 edge%0d: got %b expected %b", e, obs_of(0), exp_of(0));
      end
    end
  endtask

  task automatic test_pause();
    idle_inputs();
    load = 1'b1; load_val = 3'd4; start = 1'b1; tick_en = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    tick();
    tick();
    pause = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({q_a, busy_a} !== {3'd2, 1'b1}) begin
        n_errors++;
        $display("FAIL pause_hold cyc%0d: got Q=%0d busy=%b expected Q=2 busy=1", c, q_a, busy_a);
      end
      n_checks++;
      if (obs_of(1) !== exp_of(1)) begin
        n_errors++;
        $display("FAIL pause dut1 cyc%0d: got %b expected %b", c, obs_of(1), exp_of(1));
      end
    end
    pause = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (obs_of(0) !== exp_of(0)) begin
        n_errors++;
        $display("FAIL pause_resume cyc%0d: got %b expected %b", c, obs_of(0), exp_of(0));
      end
    end
    n_checks++;
    if ({q_a, busy_a} !== {3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL pause_final: got Q=%0d busy=%b expected Q=0 busy=0", q_a, busy_a);
    end
  endtask

  task automatic test_zero_start();
    logic [4:0] want [3];
    want[0] = {3'd0, 1'b1, 1'b0};
    want[1] = {3'd0, 1'b0, 1'b1};
    want[2] = {3'd0, 1'b0, 1'b0};
    idle_inputs();
    load = 1'b1; load_val = 3'd0; start = 1'b1; tick_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      load = 1'b0; start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_of(i) !== want[k]) begin
          n_errors++;
          $display("FAIL zero_start dut%0d edge%0d: got %b expected %b", i, k, obs_of(i), want[k]);
        end
      end
    end
    // start while busy is ignored
    load = 1'b1; load_val = 3'd6; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({q_a, busy_a} !== {3'd2, 1'b1}) begin
      n_errors++;
      $display("FAIL start_busy: got Q=%0d busy=%b expected Q=2 busy=1", q_a, busy_a);
    end
    n_checks++;
    if (obs_of(1) !== exp_of(1)) begin
      n_errors++;
      $display("FAIL start_busy dut1: got %b expected %b", obs_of(1), exp_of(1));
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    load = 1'b1; load_val = 3'd7; start = 1'b1; tick_en = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (q_a !== 3'd3) begin
      n_errors++;
      $display("FAIL reset_mid_pre: got Q=%0d expected Q=3", q_a);
    end
    reset = 1'b1;
    #2;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs_of(i) !== 5'b0) begin
        n_errors++;
        $display("FAIL reset_async dut%0d: got %b expected %b", i, obs_of(i), 5'b0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({done_a, done_b, busy_a, busy_b} !== 4'b0) begin
        n_errors++;
        $display("FAIL reset_no_done cyc%0d: got done=%b%b busy=%b%b expected all 0",
                 c, done_a, done_b, busy_a, busy_b);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [4:0] want;
    idle_inputs();
    load = 1'b1; load_val = 3'd2; start = 1'b1; tick_en = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (AUTO) want = {((e % 2) == 1) ? 3'd1 : 3'd2, 1'b1, (e % 2) == 0};
      else      want = {(e == 1) ? 3'd1 : 3'd0, (e == 1), (e == 2)};
      n_checks++;
      if (obs_of(0) !== want) begin
        n_errors++;
        $display("FAIL auto_reload edge%0d: got %b expected %b", e, obs_of(0), want);
      end
      n_checks++;
      if (obs_of(1) !== exp_of(1)) begin
        n_errors++;
        $display("FAIL auto_reload dut1 edge%0d: got %b expected %b", e, obs_of(1), exp_of(1));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick_en  = ($urandom_range(0, 1) == 1);
      load     = ($urandom_range(0, 9) == 0);
      start    = ($urandom_range(0, 5) == 0);
      pause    = ($urandom_range(0, 7) == 0);
      load_val = 3'($urandom_range(0, 7));
      tick();
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_of(i) !== exp_of(i)) begin
          n_errors++;
          $display("FAIL random dut%0d cyc%0d: got %b expected %b", i, c, obs_of(i), exp_of(i));
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_count_p1();
    test_drain(20);
    test_prescale();
    test_drain(10);
    test_pause();
    test_drain(20);
    test_zero_start();
    test_drain(25);
    test_reset_mid();
    test_auto_reload();
    test_drain(5);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
